// File: rtl/serial_comparator_ctrl_pkg.sv
// serial_comparator_ctrl_pkg: state and result encodings shared by the serial comparator and its consumers
package serial_comparator_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;
  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } res_t;
endpackage

// File: rtl/onebit_comparator.sv
// onebit_comparator: single-bit magnitude compare cell
module onebit_comparator (
  input  logic x,
  input  logic y,
  output logic g,
  output logic l,
  output logic e
);
  assign g = x & ~y;
  assign l = ~x & y;
  assign e = ~(x ^ y);
endmodule

// File: rtl/serial_comparator_ctrl.sv
// serial_comparator_ctrl: MSB-first bit-serial magnitude compare, stopping at the first differing bit
module serial_comparator_ctrl
  import serial_comparator_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       gt,
  output logic                       lt,
  output logic                       eq,
  output logic [$clog2(WIDTH):0]     cmp_cycles
);
  localparam int IDXW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDXW-1:0] idx;
  logic [IDXW:0] cnt;
  logic g, l, e, fin;
  onebit_comparator u_cell (
    .x(a_q[idx]),
    .y(b_q[idx]),
    .g(g),
    .l(l),
    .e(e)
  );
  // a mismatch or the last bit both end the walk, so idx never wraps
  assign fin = g | l | (idx == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = (state == ST_IDLE)    ? (start ? ST_COMPARE : ST_IDLE) :
               (state == ST_COMPARE) ? (fin ? ST_DONE : ST_COMPARE) :
                                       ST_IDLE;
  end
  always_comb begin
    busy = state != ST_IDLE;
    done = state == ST_DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      cnt        <= '0;
      gt         <= 1'b0;
      lt         <= 1'b0;
      eq         <= 1'b0;
      cmp_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      a_q <= a;
      b_q <= b;
      idx <= IDXW'(WIDTH - 1);
      cnt <= '0;
    end else if (state == ST_COMPARE) begin
      cnt <= cnt + 1'b1;
      if (fin) begin
        gt         <= g;
        lt         <= l;
        eq         <= e;
        cmp_cycles <= cnt + 1'b1;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// tb_serial_comparator_ctrl: directed table plus hand-written corner sequences for the serial comparator
module tb_serial_comparator_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, gt, lt, eq;
  logic [3:0] cmp_cycles;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       lt;
    logic       eq;
    int         cyc;
  } vec_t;
  vec_t vt[8];
  serial_comparator_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq), .cmp_cycles(cmp_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic run(input logic [7:0] av, input logic [7:0] bv, input logic egt, input logic elt,
                     input logic eeq, input int ecyc, input int eprev, input string tag);
    int lat;
    int bsy_bad;
    bsy_bad = 0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    chk({tag, "_hold"}, int'({gt, lt, eq, cmp_cycles}), eprev);
    while (!done && lat < 40) begin
      if (!busy) bsy_bad++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, ecyc + 1);
    chk({tag, "_busy_run"}, bsy_bad, 0);
    chk({tag, "_busy_done"}, int'(busy), 1);
    chk({tag, "_gt"}, int'(gt), int'(egt));
    chk({tag, "_lt"}, int'(lt), int'(elt));
    chk({tag, "_eq"}, int'(eq), int'(eeq));
    chk({tag, "_cyc"}, int'(cmp_cycles), ecyc);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
  endtask
  initial begin
    int prev;
    int ndone;
    int first;
    int last;
    int run_lo;
    int gt_bad;
    vt[0] = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 8};
    vt[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1};
    vt[2] = '{8'h04, 8'h05, 1'b0, 1'b1, 1'b0, 8};
    vt[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1};
    vt[4] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 8};
    vt[5] = '{8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1, 8};
    vt[6] = '{8'h12, 8'h14, 1'b0, 1'b1, 1'b0, 6};
    vt[7] = '{8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 3};
    #2;
    chk("reset_outs", int'({busy, done, gt, lt, eq, cmp_cycles}), 0);
    @(negedge clk);
    rst = 1'b0;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      run(vt[i].a, vt[i].b, vt[i].gt, vt[i].lt, vt[i].eq, vt[i].cyc, prev, $sformatf("vec%0d", i));
      prev = int'({vt[i].gt, vt[i].lt, vt[i].eq, 4'(vt[i].cyc)});
    end
    // start during COMPARE must be ignored and must not disturb the captured operands
    ndone = 0;
    first = -1;
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin a = 8'hFF; b = 8'h00; end
      if (i == 2) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    chk("ign_first_done", first, 4);
    chk("ign_ndone", ndone, 1);
    chk("ign_lt", int'({gt, lt, eq}), 3'b010);
    chk("ign_cyc", int'(cmp_cycles), 3);
    // asynchronous reset mid-COMPARE
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_outs", int'({busy, done, gt, lt, eq, cmp_cycles}), 0);
    @(negedge clk);
    chk("arst_held", int'({busy, done}), 0);
    rst = 1'b0;
    run(8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 7, 0, "post_rst");
    // continuous start: back-to-back comparisons every three cycles
    ndone = 0;
    last = -1;
    run_lo = 0;
    gt_bad = 0;
    @(negedge clk);
    a = 8'hC0; b = 8'h40; start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (!gt) gt_bad++;
      if (done) begin
        ndone++;
        if (last >= 0) chk("hold_period", i - last, 3);
        last = i;
      end
      if (!busy) run_lo++;
      else if (run_lo > 0) begin
        chk("hold_busy_gap", run_lo, 1);
        run_lo = 0;
      end
    end
    start = 1'b0;
    chk("hold_ndone", ndone, 10);
    chk("hold_gt_stable", gt_bad, 0);
    chk("hold_cyc", int'(cmp_cycles), 1);
    repeat (4) @(negedge clk);
    chk("final_idle", int'({busy, done}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
